bcd_to_seven_segment: RTL and testbench



---
 rtl/bcd_to_seven_segment.sv | 106 ++++++++++
 tb/tb_bcd_to_seven_segment.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/bcd_to_seven_segment.sv
// Registered BCD-to-seven-segment decoder with lamp-test, blanking and
// ripple-blanking controls; one instance per display digit.
//
// Parameters:
//   ACTIVE_LOW : 0 = lit segment drives 1 (common cathode),
//                1 = all of a..g inverted (common anode); rbo/err unaffected.
// Ports:
//   clk            clock
//   rst            asynchronous active-high reset (segments off, rbo=0, err=0)
//   bcd[3:0]       digit in; 0-9 valid, 10-15 invalid (decoded as blank)
//   lt             lamp test, lights all segments
//   bi             blanking input, turns all segments off (highest priority)
//   rbi            ripple-blank input, blanks a zero digit
//   a..g           registered segment drives
//   rbo            registered ripple-blank output to the next lower digit
//   err            registered flag, sampled bcd was 10-15
module bcd_to_seven_segment #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bcd,
    input  logic       lt,
    input  logic       bi,
    input  logic       rbi,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       rbo,
    output logic       err
);

    localparam int unsigned SEG_W = 7;

    // Physical "all off" pattern, which depends on the drive polarity.
    localparam logic [SEG_W-1:0] SEG_OFF = {SEG_W{ACTIVE_LOW}};

    // Segment vectors are ordered {a,b,c,d,e,f,g}, a in the MSB.
    logic [SEG_W-1:0] dec_lit;
    logic [SEG_W-1:0] seg_lit;
    logic [SEG_W-1:0] seg_d;
    logic [SEG_W-1:0] seg_q;
    logic             rbo_d;
    logic             rbo_q;
    logic             err_d;
    logic             err_q;

    // Digit map in logical (lit = 1) form; invalid codes decode to blank.
    always_comb begin
        dec_lit = '0;
        case (bcd)
            4'd0:    dec_lit = 7'b1111110;
            4'd1:    dec_lit = 7'b0110000;
            4'd2:    dec_lit = 7'b1101101;
            4'd3:    dec_lit = 7'b1111001;
            4'd4:    dec_lit = 7'b0110011;
            4'd5:    dec_lit = 7'b1011011;
            4'd6:    dec_lit = 7'b1011111;
            4'd7:    dec_lit = 7'b1110000;
            4'd8:    dec_lit = 7'b1111111;
            4'd9:    dec_lit = 7'b1111011;
            default: dec_lit = '0;
        endcase
    end

    // Control priority bi > lt > ripple-blank > decode; polarity applied
    // before the register so the pins see a clean flop output.
    always_comb begin
        seg_lit = '0;
        rbo_d   = 1'b0;
        err_d   = (bcd > 4'd9);
        if (bi) begin
            seg_lit = '0;
        end else if (lt) begin
            seg_lit = '1;
        end else if (rbi && (bcd == 4'd0)) begin
            seg_lit = '0;
            rbo_d   = 1'b1;
        end else begin
            seg_lit = dec_lit;
        end
        seg_d = ACTIVE_LOW ? ~seg_lit : seg_lit;
    end

    // Output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= SEG_OFF;
            rbo_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            seg_q <= seg_d;
            rbo_q <= rbo_d;
            err_q <= err_d;
        end
    end

    assign {a, b, c, d, e, f, g} = seg_q;
    assign rbo = rbo_q;
    assign err = err_q;

endmodule

// File: tb/tb_bcd_to_seven_segment.sv
// Scoreboard bench for bcd_to_seven_segment: a common-cathode and a
// common-anode instance share the same inputs; directed vectors push their
// hand-computed expectations, and a monitor compares one cycle later.
module tb_bcd_to_seven_segment;

    logic       clk;
    logic       rst;
    logic [3:0] bcd;
    logic       lt;
    logic       bi;
    logic       rbi;

    logic a0, b0, c0, d0, e0, f0, g0, rbo0, err0;
    logic a1, b1, c1, d1, e1, f1, g1, rbo1, err1;

    bcd_to_seven_segment #(.ACTIVE_LOW(1'b0)) dut_cc (
        .clk(clk), .rst(rst), .bcd(bcd), .lt(lt), .bi(bi), .rbi(rbi),
        .a(a0), .b(b0), .c(c0), .d(d0), .e(e0), .f(f0), .g(g0),
        .rbo(rbo0), .err(err0)
    );

    bcd_to_seven_segment #(.ACTIVE_LOW(1'b1)) dut_ca (
        .clk(clk), .rst(rst), .bcd(bcd), .lt(lt), .bi(bi), .rbi(rbi),
        .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1),
        .rbo(rbo1), .err(err1)
    );

    typedef struct {
        string      name;
        logic [6:0] seg;   // logical a..g, lit = 1
        logic       rbo;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   n_total;
    int   n_pass;
    logic in_flight;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_cc();
        return {a0, b0, c0, d0, e0, f0, g0};
    endfunction

    function automatic logic [6:0] seg_ca();
        return {a1, b1, c1, d1, e1, f1, g1};
    endfunction

    task automatic check7(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // Full output check: common-anode segments are the bitwise inverse.
    task automatic check_all(input string name, input logic [6:0] seg, input logic rb, input logic er);
        check7({name, " seg"},    seg_cc(), seg);
        check7({name, " seg_ca"}, seg_ca(), ~seg);
        check1({name, " rbo"},    rbo0,     rb);
        check1({name, " rbo_ca"}, rbo1,     rb);
        check1({name, " err"},    err0,     er);
        check1({name, " err_ca"}, err1,     er);
    endtask

    // Drive a vector now and push its expected response.
    task automatic set_vec(input string name, input logic [3:0] v, input logic l,
                           input logic bl, input logic rb_in,
                           input logic [6:0] seg, input logic rb, input logic er);
        exp_t x;
        bcd = v; lt = l; bi = bl; rbi = rb_in;
        x.name = name; x.seg = seg; x.rbo = rb; x.err = er;
        exp_q.push_back(x);
        in_flight = 1'b1;
    endtask

    task automatic send(input string name, input logic [3:0] v, input logic l,
                        input logic bl, input logic rb_in,
                        input logic [6:0] seg, input logic rb, input logic er);
        @(negedge clk);
        set_vec(name, v, l, bl, rb_in, seg, rb, er);
    endtask

    // Monitor: each edge that sampled an issued vector yields one response.
    initial begin
        forever begin
            @(posedge clk);
            if (in_flight && !rst) begin
                #1;
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL scoreboard: response with empty queue, got %b expected none", seg_cc());
                end else begin
                    exp_t x;
                    x = exp_q.pop_front();
                    check_all(x.name, x.seg, x.rbo, x.err);
                end
            end
        end
    end

    initial begin
        n_total = 0; n_pass = 0; in_flight = 1'b0;
        rst = 1'b0; bcd = 4'd8; lt = 1'b0; bi = 1'b0; rbi = 1'b0;
        #2 rst = 1'b1;
        #1 check_all("reset_async", 7'b0000000, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 check_all("reset_held", 7'b0000000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Digit sweep
        send("d0", 4'd0, 0, 0, 0, 7'b1111110, 0, 0);
        send("d1", 4'd1, 0, 0, 0, 7'b0110000, 0, 0);
        send("d2", 4'd2, 0, 0, 0, 7'b1101101, 0, 0);
        send("d3", 4'd3, 0, 0, 0, 7'b1111001, 0, 0);
        send("d4", 4'd4, 0, 0, 0, 7'b0110011, 0, 0);
        send("d5", 4'd5, 0, 0, 0, 7'b1011011, 0, 0);
        send("d6", 4'd6, 0, 0, 0, 7'b1011111, 0, 0);
        send("d7", 4'd7, 0, 0, 0, 7'b1110000, 0, 0);
        send("d8", 4'd8, 0, 0, 0, 7'b1111111, 0, 0);
        send("d9", 4'd9, 0, 0, 0, 7'b1111011, 0, 0);
        // Invalid codes
        send("d10", 4'd10, 0, 0, 0, 7'b0000000, 0, 1);
        send("d11", 4'd11, 0, 0, 0, 7'b0000000, 0, 1);
        send("d12", 4'd12, 0, 0, 0, 7'b0000000, 0, 1);
        send("d13", 4'd13, 0, 0, 0, 7'b0000000, 0, 1);
        send("d14", 4'd14, 0, 0, 0, 7'b0000000, 0, 1);
        send("d15", 4'd15, 0, 0, 0, 7'b0000000, 0, 1);
        send("back3", 4'd3, 0, 0, 0, 7'b1111001, 0, 0);
        // Control priority
        send("lt_1",      4'd1,  1, 0, 0, 7'b1111111, 0, 0);
        send("bi_lt",     4'd1,  1, 1, 0, 7'b0000000, 0, 0);
        send("rbi_0",     4'd0,  0, 0, 1, 7'b0000000, 1, 0);
        send("rbi_5",     4'd5,  0, 0, 1, 7'b1011011, 0, 0);
        send("bi_err",    4'd12, 0, 1, 0, 7'b0000000, 0, 1);
        send("lt_err",    4'd14, 1, 0, 0, 7'b1111111, 0, 1);
        send("lt_rbi_0",  4'd0,  1, 0, 1, 7'b1111111, 0, 0);
        send("all3_0",    4'd0,  1, 1, 1, 7'b0000000, 0, 0);
        send("rbi_10",    4'd10, 0, 0, 1, 7'b0000000, 0, 1);
        send("bi_rbi_0",  4'd0,  0, 1, 1, 7'b0000000, 0, 0);

        // Mid-stream reset while showing 8
        send("pre_rst8", 4'd8, 0, 0, 0, 7'b1111111, 0, 0);
        @(posedge clk);
        #3;
        in_flight = 1'b0;
        rst = 1'b1;
        #1 check_all("rst_mid", 7'b0000000, 1'b0, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1 check_all("rst_hold", 7'b0000000, 1'b0, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        set_vec("post_rst8", 4'd8, 0, 0, 0, 7'b1111111, 0, 0);
        send("post_rst0", 4'd0, 0, 0, 0, 7'b1111110, 0, 0);

        @(negedge clk);
        in_flight = 1'b0;
        // Bounded drain of outstanding expectations
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
